// File: rtl/cpu_package.sv
// Shared types for the multi-cycle control path: instruction classes,
// sequencer states and the sequential PC increment.
package cpu_package;

  typedef enum logic [2:0] {
    R       = 3'd0,
    I_ALU   = 3'd1,
    LOAD    = 3'd2,
    STORE   = 3'd3,
    BRANCH  = 3'd4,
    JAL     = 3'd5,
    ILLEGAL = 3'd6
  } instruction_type_t;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } seq_state_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/seq_timeout_counter.sv
// Bus wait-state counter: counts cycles spent waiting for an ack and flags
// when TIMEOUT waits have already elapsed.
module seq_timeout_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic count_i,
  output logic at_limit_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign at_limit_o = (cnt_q == CW'(TIMEOUT));

  // Saturates at the limit; the sequencer leaves the wait state on that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (count_i && !at_limit_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC and walks each instruction
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a bus-timeout trap.
// Optional perf counters are enabled with CORE_SEQUENCER_PERF_EN.
module core_sequencer
  import cpu_package::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  instruction_type_t     instruction_type,
  input  logic                  alu_zero,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  imem_ack,
  input  logic                  dmem_ack,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  imem_req,
  output logic                  ir_write,
  output logic                  alu_en,
  output logic                  dmem_req,
  output logic                  dmem_write,
  output logic                  reg_write,
  output logic                  retire,
  output logic                  trap,
`ifdef CORE_SEQUENCER_PERF_EN
  output logic [31:0]           retired_count,
  output logic [31:0]           stall_count,
`endif
  output seq_state_t            state
);

  seq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  active_q;
  logic                  waiting;
  logic                  at_limit;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] target_aligned;
  logic                  unused_target_lsbs;

  assign pc_inc             = pc_q + ADDR_WIDTH'(PC_STEP);
  assign target_aligned     = {branch_target[ADDR_WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];

  // active_q holds the machine idle for the cycle after reset release so the
  // first fetch request appears on the first clock edge, not at release.
  assign waiting = active_q && (((state_q == FETCH) && !imem_ack) ||
                                ((state_q == MEM)   && !dmem_ack));

  seq_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (!waiting),
    .count_i    (waiting),
    .at_limit_o (at_limit)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (active_q) begin
      case (state_q)
        FETCH: begin
          if (imem_ack)      state_d = DECODE;
          else if (at_limit) state_d = TRAP;
        end
        DECODE: state_d = (instruction_type == ILLEGAL) ? TRAP : EXECUTE;
        EXECUTE: begin
          case (instruction_type)
            LOAD, STORE: state_d = MEM;
            BRANCH: begin
              state_d = FETCH;
              pc_d    = alu_zero ? target_aligned : pc_inc;
            end
            default: state_d = WRITEBACK;
          endcase
        end
        MEM: begin
          if (dmem_ack) begin
            if (instruction_type == STORE) begin
              state_d = FETCH;
              pc_d    = pc_inc;
            end else begin
              state_d = WRITEBACK;
            end
          end else if (at_limit) begin
            state_d = TRAP;
          end
        end
        WRITEBACK: begin
          state_d = FETCH;
          pc_d    = (instruction_type == JAL) ? target_aligned : pc_inc;
        end
        TRAP:    state_d = TRAP;
        default: state_d = TRAP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      active_q <= 1'b1;
    end
  end

  assign pc         = pc_q;
  assign state      = state_q;
  assign trap       = (state_q == TRAP);
  assign imem_req   = active_q && (state_q == FETCH);
  assign ir_write   = imem_req && imem_ack;
  assign alu_en     = active_q && (state_q == EXECUTE);
  assign dmem_req   = active_q && (state_q == MEM);
  assign dmem_write = dmem_req && (instruction_type == STORE);
  assign reg_write  = active_q && (state_q == WRITEBACK);
  assign retire     = reg_write ||
                      (alu_en && (instruction_type == BRANCH)) ||
                      (dmem_write && dmem_ack);

`ifdef CORE_SEQUENCER_PERF_EN
  logic [31:0] retired_q, stall_q;

  // Neither retire nor waiting can assert in TRAP, so both counters freeze there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire)  retired_q <= retired_q + 32'd1;
      if (waiting) stall_q   <= stall_q + 32'd1;
    end
  end

  assign retired_count = retired_q;
  assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: a per-instruction cycle schedule is derived from
// the latency/handshake rules and compared against the DUT every cycle.
module tb_core_sequencer;
  import cpu_package::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic reset_n = 1'b0;
  instruction_type_t itype = ILLEGAL;
  logic alu_zero = 1'b0, iack = 1'b0, dack = 1'b0;
  logic [31:0] bt = '0, pc;
  logic imem_req, ir_write, alu_en, dmem_req, dmem_write, reg_write, retire, trap;
  seq_state_t state;

  // 8-bit instance
  logic reset_n8 = 1'b0;
  instruction_type_t itype8 = STORE;
  logic az8 = 1'b0, iack8 = 1'b0, dack8 = 1'b0;
  logic [7:0] bt8 = 8'h00, pc8;
  logic imem_req8, ir_write8, alu_en8, dmem_req8, dmem_write8, reg_write8, retire8, trap8;
  seq_state_t state8;

`ifdef CORE_SEQUENCER_PERF_EN
  logic [31:0] retired_count, stall_count, retired_count8, stall_count8;
`endif

  core_sequencer #(.ADDR_WIDTH(32), .RESET_PC(32'h100), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .instruction_type(itype), .alu_zero(alu_zero),
    .branch_target(bt), .imem_ack(iack), .dmem_ack(dack), .pc(pc),
    .imem_req(imem_req), .ir_write(ir_write), .alu_en(alu_en), .dmem_req(dmem_req),
    .dmem_write(dmem_write), .reg_write(reg_write), .retire(retire), .trap(trap),
`ifdef CORE_SEQUENCER_PERF_EN
    .retired_count(retired_count), .stall_count(stall_count),
`endif
    .state(state));

  core_sequencer #(.ADDR_WIDTH(8), .RESET_PC(8'hFC), .TIMEOUT(3)) dut8 (
    .clk(clk), .reset_n(reset_n8), .instruction_type(itype8), .alu_zero(az8),
    .branch_target(bt8), .imem_ack(iack8), .dmem_ack(dack8), .pc(pc8),
    .imem_req(imem_req8), .ir_write(ir_write8), .alu_en(alu_en8), .dmem_req(dmem_req8),
    .dmem_write(dmem_write8), .reg_write(reg_write8), .retire(retire8), .trap(trap8),
`ifdef CORE_SEQUENCER_PERF_EN
    .retired_count(retired_count8), .stall_count(stall_count8),
`endif
    .state(state8));

  typedef struct {
    logic iack, dack, az;
    instruction_type_t it;
    logic [31:0] bt;
    logic ireq, irw, alu, dreq, dwr, rw, ret, trp;
    logic [31:0] pc;
  } cyc_t;

  cyc_t sched[$];
  cyc_t cur;
  bit   cur_vld = 1'b0;
  int   errors = 0, checks = 0;
  logic [31:0] m_pc;
  int   m_ret, m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t idle_cyc();
    cyc_t c;
    c.iack = 0; c.dack = 0; c.az = 0; c.it = ILLEGAL; c.bt = '0;
    c.ireq = 0; c.irw = 0; c.alu = 0; c.dreq = 0; c.dwr = 0; c.rw = 0; c.ret = 0; c.trp = 0;
    c.pc = m_pc;
    return c;
  endfunction

  task automatic push(input cyc_t c);
    sched.push_back(c);
    if (c.ret) m_ret++;
    if ((c.ireq && !c.iack) || (c.dreq && !c.dack)) m_stall++;
  endtask

  task automatic add_trap(input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = idle_cyc(); c.trp = 1; c.iack = 1; c.dack = 1; c.it = STORE; c.az = 1; c.bt = 32'h80;
      push(c);
    end
  endtask

  // One instruction: (iw+1) fetch cycles, decode, execute, optional (dw+1)
  // memory cycles, optional writeback; noise drives acks where they must be ignored.
  task automatic add_instr(input instruction_type_t it, input int iw, input int dw,
                           input logic az, input logic [31:0] tgt, input bit noise);
    cyc_t c;
    for (int k = 0; k <= iw; k++) begin
      c = idle_cyc(); c.ireq = 1; c.iack = (k == iw); c.irw = c.iack; c.dack = noise;
      c.az = az; c.bt = tgt; push(c);
    end
    c = idle_cyc(); c.it = it; c.iack = noise; c.dack = noise; c.az = az; c.bt = tgt; push(c);
    if (it == ILLEGAL) begin
      add_trap(4);
      return;
    end
    c = idle_cyc(); c.it = it; c.iack = noise; c.dack = noise; c.az = az; c.bt = tgt;
    c.alu = 1; c.ret = (it == BRANCH); push(c);
    if (it == LOAD || it == STORE) begin
      for (int k = 0; k <= dw; k++) begin
        c = idle_cyc(); c.it = it; c.iack = noise; c.az = az; c.bt = tgt;
        c.dreq = 1; c.dwr = (it == STORE); c.dack = (k == dw); c.ret = (it == STORE) && (k == dw);
        push(c);
      end
    end
    if (it != BRANCH && it != STORE) begin
      c = idle_cyc(); c.it = it; c.iack = noise; c.dack = noise; c.az = az; c.bt = tgt;
      c.rw = 1; c.ret = 1; push(c);
    end
    if (it == JAL || (it == BRANCH && az)) m_pc = tgt & ~32'h3;
    else                                   m_pc = m_pc + 32'd4;
  endtask

  task automatic add_timeout();
    cyc_t c;
    for (int k = 0; k < 16; k++) begin
      c = idle_cyc(); c.ireq = 1; c.dack = 1; push(c);
    end
    add_trap(4);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cur = sched[i];
      iack = cur.iack; dack = cur.dack; itype = cur.it; alu_zero = cur.az; bt = cur.bt;
      cur_vld = 1'b1;
    end
    @(negedge clk); #1;
    cur_vld = 1'b0;
  endtask

  task automatic start_phase();
    sched.delete();
    m_pc = 32'h100; m_ret = 0; m_stall = 0;
  endtask

  always @(negedge clk) begin
    if (cur_vld) begin
      check("imem_req", {31'd0, imem_req}, {31'd0, cur.ireq});
      check("ir_write", {31'd0, ir_write}, {31'd0, cur.irw});
      check("alu_en", {31'd0, alu_en}, {31'd0, cur.alu});
      check("dmem_req", {31'd0, dmem_req}, {31'd0, cur.dreq});
      if (cur.dreq) check("dmem_write", {31'd0, dmem_write}, {31'd0, cur.dwr});
      check("reg_write", {31'd0, reg_write}, {31'd0, cur.rw});
      check("retire", {31'd0, retire}, {31'd0, cur.ret});
      check("trap", {31'd0, trap}, {31'd0, cur.trp});
      check("pc", pc, cur.pc);
    end
  end

  initial begin
    // Phase A: reset state, then a mixed instruction stream ending in a timeout trap
    start_phase();
    #12;
    check("rst_pc", pc, 32'h100);
    check("rst_state", {29'd0, state}, {29'd0, FETCH});
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    add_instr(R, 0, 0, 1'b0, 32'hDEAD_BEE0, 1'b0);
    check("model_r_len", sched.size(), 32'd4);
    check("model_r_pc", m_pc, 32'h104);
    add_instr(LOAD, 0, 3, 1'b1, 32'h0000_0F00, 1'b0);
    check("model_load_len", sched.size(), 32'd12);
    add_instr(BRANCH, 1, 0, 1'b0, 32'h203, 1'b0);
    add_instr(BRANCH, 0, 0, 1'b1, 32'h203, 1'b0);
    check("model_branch_pc", m_pc, 32'h200);
    add_instr(STORE, 2, 1, 1'b1, 32'h0000_0700, 1'b1);
    add_instr(JAL, 0, 0, 1'b0, 32'h3FF, 1'b0);
    add_instr(I_ALU, 15, 0, 1'b0, 32'h0000_0500, 1'b0);
    add_timeout();
    @(negedge clk); reset_n = 1'b1;
    #1 check("release_imem_req", {31'd0, imem_req}, 32'd0);
    run(sched.size());
    check("end_a_pc", pc, 32'h400);
    check("end_a_trap", {31'd0, trap}, 32'd1);
    check("end_a_imem_req", {31'd0, imem_req}, 32'd0);
`ifdef CORE_SEQUENCER_PERF_EN
    check("retired_count", retired_count, m_ret);
    check("stall_count", stall_count, m_stall);
`endif

    // Phase B: async reset out of TRAP, then ILLEGAL decode
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    check("rstB_trap", {31'd0, trap}, 32'd0);
    check("rstB_pc", pc, 32'h100);
    check("rstB_state", {29'd0, state}, {29'd0, FETCH});
    start_phase();
    add_instr(R, 0, 0, 1'b0, 32'h0, 1'b0);
    add_instr(ILLEGAL, 1, 0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    run(sched.size());
    check("illegal_trap", {31'd0, trap}, 32'd1);
    check("illegal_pc", pc, 32'h104);

    // Phase C: reset asserted mid-MEM drops dmem_req without a clock edge
    @(posedge clk); #3 reset_n = 1'b0;
    start_phase();
    add_instr(R, 0, 0, 1'b0, 32'h0, 1'b0);
    add_instr(STORE, 0, 5, 1'b0, 32'h0, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    run(9);
    check("midmem_dmem_req", {31'd0, dmem_req}, 32'd1);
    check("midmem_pc", pc, 32'h104);
    reset_n = 1'b0;
    #1;
    check("midmem_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("midmem_rst_pc", pc, 32'h100);

    // Phase D: 8-bit PC wraps on STORE, then a short timeout
    check("w8_rst_pc", {24'd0, pc8}, 32'hFC);
    @(negedge clk); reset_n8 = 1'b1;
    @(posedge clk); #1 iack8 = 1'b1;
    #1 check("w8_ir_write", {31'd0, ir_write8}, 32'd1);
    @(posedge clk); #1 iack8 = 1'b0;
    #1 check("w8_decode", {29'd0, state8}, {29'd0, DECODE});
    @(posedge clk); #2 check("w8_alu_en", {31'd0, alu_en8}, 32'd1);
    @(posedge clk); #1 dack8 = 1'b1;
    #1;
    check("w8_dmem_write", {31'd0, dmem_write8}, 32'd1);
    check("w8_retire", {31'd0, retire8}, 32'd1);
    check("w8_pc_before", {24'd0, pc8}, 32'hFC);
    @(posedge clk); #1 dack8 = 1'b0;
    #1;
    check("w8_pc_wrap", {24'd0, pc8}, 32'h00);
    check("w8_fetch_req", {31'd0, imem_req8}, 32'd1);
    repeat (3) @(posedge clk);
    #2 check("w8_before_trap", {31'd0, trap8}, 32'd0);
    @(posedge clk); #2;
    check("w8_trap", {31'd0, trap8}, 32'd1);
    check("w8_trap_req", {31'd0, imem_req8}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle successor to the single-cycle control path. Owns the program counter and sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Memories are reached over a req/ack handshake, so imem and dmem may insert wait states.
- Sits between the decoder (supplies instruction_type, alu_zero, branch_target) and the datapath (consumes the enables below).
- PC width is parametrised; a bus-timeout trap is added.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width in bits (≥3).
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0.
- TIMEOUT, 15, maximum wait cycles for an ack before trapping (≥1).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- instruction_type  in  instruction_type_t  decoded class of the instruction register: R, I_ALU, LOAD, STORE, BRANCH, JAL, ILLEGAL
- alu_zero  in  1  ALU zero flag, valid during EXECUTE
- branch_target  in  ADDR_WIDTH  taken-branch/jump target from the datapath
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- pc  out  ADDR_WIDTH  current PC; also drives the imem address
- imem_req  out  1  instruction fetch request
- ir_write  out  1  latch imem data into the instruction register
- alu_en  out  1  ALU result register enable
- dmem_req  out  1  data memory request
- dmem_write  out  1  store qualifier, valid only while dmem_req=1
- reg_write  out  1  register file write enable
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky fault indicator
- state  out  seq_state_t  current state, for debug and the bench

Behaviour:
Reset:
- Asynchronous, active-low.
- pc=RESET_PC; state=FETCH; wait counter=0; trap=0.
- All enables and requests 0 while reset_n=0, including mid-transaction: any outstanding req drops immediately.
- First fetch request rises on the first clock edge after reset release.

Output timing:
- All outputs are Moore, decoded from state, except ir_write.
- ir_write = imem_ack & (state==FETCH).

State transitions:
- FETCH: imem_req=1; hold until imem_ack.
  - On ack: ir_write=1 in that cycle; next DECODE.
- DECODE: 1 cycle, no enables; next EXECUTE.
  - instruction_type==ILLEGAL: next TRAP.
- EXECUTE: alu_en=1.
  - LOAD/STORE: next MEM.
  - R/I_ALU/JAL: next WRITEBACK.
  - BRANCH: retire=1; pc <= alu_zero ? branch_target : pc+4; next FETCH.
- MEM: dmem_req=1; dmem_write=1 for STORE only; hold until dmem_ack.
  - STORE on ack: retire=1; pc<=pc+4; next FETCH.
  - LOAD on ack: next WRITEBACK.
- WRITEBACK: reg_write=1 for exactly 1 cycle; retire=1.
  - pc <= (JAL ? branch_target : pc+4); next FETCH.
- TRAP: all requests and enables 0; trap=1; pc frozen. Left only by reset.

Instruction latency (no wait states):
- BRANCH 3 cycles; STORE 4; R/I/JAL 4; LOAD 5.
- Each wait cycle adds 1.

Arithmetic and width rules:
- pc+4 is computed modulo 2^ADDR_WIDTH: {all ones except [1:0]} wraps to 0.
- branch_target[1:0] is ignored; the loaded pc has [1:0]=0.

Timeout:
- Wait counter clears on entry to FETCH or MEM.
- Increments each cycle in FETCH/MEM without ack.
- Counter==TIMEOUT with no ack: next TRAP.
- Ack in the same cycle the counter reaches TIMEOUT: ack wins, normal transition.

Ack handling:
- Acks outside the matching state (imem_ack outside FETCH, dmem_ack outside MEM) are ignored.
- Simultaneous imem_ack and dmem_ack: only the one matching the current state is used.
- instruction_type is sampled only in DECODE, EXECUTE, MEM and WRITEBACK; the datapath must hold the IR stable across them.

Optional Feature:
- Macro: CORE_SEQUENCER_PERF_EN.
- Defined:
  - Two 32-bit output ports: retired_count (increments on retire) and stall_count (increments each FETCH/MEM cycle without ack).
  - Both reset to 0, wrap at 2^32, and freeze in TRAP.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- cpu_package gains:
  - seq_state_t enum (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP).
  - instruction_type_t extended with LOAD, STORE, BRANCH, JAL, ILLEGAL if not already present.
  - Constant PC_STEP=4.
- One sub-module: seq_timeout_counter (clear, count, reaching-limit flag; parametrised by TIMEOUT).
- FSM and PC stay in core_sequencer.

Test Plan:
- Reset with RESET_PC=0x100; R-type; imem_ack after 0 waits -> imem_req high at cycle 1; reg_write high exactly 1 cycle at cycle 4; retire at cycle 4; pc=0x104.
- LOAD with dmem_ack after 3 waits -> dmem_req high 4 cycles with dmem_write=0; reg_write 1 cycle later; total 8 cycles; pc+4.
- BRANCH with alu_zero=1, branch_target=0x203 -> pc=0x200 after 3 cycles. Repeat with alu_zero=0 -> pc=0x104.
- ADDR_WIDTH=8, pc=0xFC, STORE -> dmem_write=1 during MEM; pc wraps to 0x00.
- TIMEOUT=15: imem_ack withheld -> TRAP after the 16th FETCH cycle, trap=1, imem_req=0. Second run: ack on that same cycle -> DECODE, no trap.
- Assert reset_n mid-MEM -> dmem_req falls with no clock edge; pc=RESET_PC. ILLEGAL decode -> TRAP; retire never pulses.
